cpu_trace_buffer: RTL and testbench

Synthesizable, parametrised probe monitor for the CPU data path: samples CHANNELS probe words each clock and records a timestamped entry into an internal FIFO whenever any probe changes, during a bounded capture window. It is the in-hardware successor to a print-on-change simulation monitor with a fixed run length. It sits beside the `cpu` top, fed with register-file, memory, state and PC-mux taps, and is drained by a debug reader through a first-word-fall-through read port.

---
 rtl/cpu_trace_buffer.sv | 132 +++++++++++++
 tb/tb_cpu_trace_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// Change-triggered probe recorder: timestamped {ts, probe} entries into a FWFT FIFO during a bounded window.
// Optional build macro TRACE_STOP_ON_FULL_EN ends the capture when the FIFO fills instead of dropping entries.
module cpu_trace_buffer #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16,
    parameter int WINDOW   = 1000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNELS*WIDTH-1:0]          probe,
    input  logic                               arm,
    input  logic                               stop,
    input  logic                               rd_en,
    output logic [TS_WIDTH+CHANNELS*WIDTH-1:0] rd_data,
    output logic                               rd_valid,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               overflow,
    output logic                               capturing,
    output logic                               done
);

    localparam int PW = CHANNELS * WIDTH;
    localparam int EW = TS_WIDTH + PW;
    localparam int AW = $clog2(DEPTH);
    localparam logic [TS_WIDTH-1:0] TS_LAST = TS_WIDTH'(WINDOW - 1);
    localparam logic [AW:0]         FULL    = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t              state, next_state;
    logic [TS_WIDTH-1:0] ts;
    logic [PW-1:0]       prev;
    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [AW:0]         cnt;

    logic                full, pop, push_req, do_push, drop;
    logic [EW-1:0]       push_entry;
`ifdef TRACE_STOP_ON_FULL_EN
    localparam logic [AW:0] ALMOST = (AW + 1)'(DEPTH - 1);
    logic                fill;
`endif

    // arm flushes the FIFO, so it suppresses both push and pop in its cycle
    always_comb begin
        full       = (cnt == FULL);
        pop        = rd_en && (cnt != '0) && !arm;
        push_req   = !arm && ((state == ARMED) || ((state == CAPTURE) && (probe != prev)));
        push_entry = (state == ARMED) ? {{TS_WIDTH{1'b0}}, probe} : {ts, probe};
        do_push    = push_req && (!full || pop);
        drop       = push_req && full && !pop;
`ifdef TRACE_STOP_ON_FULL_EN
        fill       = do_push && !pop && (cnt == ALMOST);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (arm) begin
            next_state = ARMED;
        end else begin
            case (state)
                ARMED:   next_state = CAPTURE;
                CAPTURE: if ((ts >= TS_LAST) || stop) next_state = DONE;
                default: ;
            endcase
`ifdef TRACE_STOP_ON_FULL_EN
            if (fill) next_state = DONE;
`endif
        end
    end

    always_comb begin
        capturing = (state == ARMED) || (state == CAPTURE);
        done      = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts   <= '0;
            prev <= '0;
        end else if (arm) begin
            ts <= '0;
        end else if (state == ARMED) begin
            ts   <= TS_WIDTH'(1);
            prev <= probe;
        end else if (state == CAPTURE) begin
            ts   <= ts + TS_WIDTH'(1);
            prev <= probe;
        end
    end

    // Storage is cleared only by rst; arm just resets the pointers and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (arm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: ;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

    assign rd_data  = mem[rd_ptr];
    assign rd_valid = (cnt != '0);
    assign count    = cnt;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_cpu_trace_buffer;

    localparam int W   = 8;
    localparam int CH  = 2;
    localparam int D   = 4;
    localparam int TSW = 4;
    localparam int WIN = 8;
    localparam int PW  = W * CH;
    localparam int EW  = TSW + PW;
    localparam int CW  = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] probe = '0;
    logic          arm = 1'b0, stop = 1'b0, rd_en = 1'b0;
    logic [EW-1:0] rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          overflow, capturing, done;

    cpu_trace_buffer #(
        .WIDTH(W), .CHANNELS(CH), .DEPTH(D), .TS_WIDTH(TSW), .WINDOW(WIN)
    ) dut (
        .clk(clk), .rst(rst), .probe(probe), .arm(arm), .stop(stop), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .overflow(overflow),
        .capturing(capturing), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: recorded entries as a queue, window position as a plain cycle count
    typedef enum {P_IDLE, P_ARMED, P_CAPTURE, P_DONE} phase_t;
    phase_t        phase = P_IDLE;
    logic [EW-1:0] mq[$];
    bit            m_ovf = 0;
    int            m_ts = 0;
    logic [PW-1:0] m_prev = '0;
    int            total = 0;
    int            bad = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_count"}, 64'(count), 64'(mq.size()));
        checkOutput({tag, "_valid"}, 64'(rd_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) checkOutput({tag, "_data"}, 64'(rd_data), 64'(mq[0]));
        checkOutput({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
        checkOutput({tag, "_capt"}, 64'(capturing), 64'(phase == P_ARMED || phase == P_CAPTURE));
        checkOutput({tag, "_done"}, 64'(done), 64'(phase == P_DONE));
    endtask

    task automatic modelStep(input bit a, input bit s, input bit r, input logic [PW-1:0] p);
        bit            want, popped;
        int            size_before;
        logic [EW-1:0] entry;
        if (a) begin
            mq.delete();
            m_ovf = 0;
            m_ts  = 0;
            phase = P_ARMED;
            return;
        end
        want   = 0;
        entry  = '0;
        popped = r && (mq.size() > 0);
        case (phase)
            P_ARMED: begin
                want   = 1;
                entry  = {TSW'(0), p};
                m_prev = p;
                m_ts   = 1;
                phase  = P_CAPTURE;
            end
            P_CAPTURE: begin
                want   = (p != m_prev);
                entry  = {TSW'(m_ts), p};
                m_prev = p;
                if (m_ts == WIN - 1 || s) phase = P_DONE;
                m_ts++;
            end
            default: ;
        endcase
        size_before = mq.size();
        if (popped) void'(mq.pop_front());
        if (want) begin
            if (mq.size() < D) begin
                mq.push_back(entry);
`ifdef TRACE_STOP_ON_FULL_EN
                if (size_before == D - 1 && !popped) phase = P_DONE;
`endif
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    // One clock: check outputs settled from the previous edge, then drive inputs for the next edge
    task automatic applyStimulus(input bit a, input bit s, input bit r, input logic [PW-1:0] p);
        @(negedge clk);
        checkState("cyc");
        arm   = a;
        stop  = s;
        rd_en = r;
        probe = p;
        modelStep(a, s, r, p);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        mq.delete();
        m_ovf  = 0;
        m_ts   = 0;
        m_prev = '0;
        phase  = P_IDLE;
        checkState("rst");
        checkOutput("rst_data", 64'(rd_data), 64'(0));
        #1;
        rst   = 1'b0;
        arm   = 1'b0;
        stop  = 1'b0;
        rd_en = 1'b0;
        modelStep(0, 0, 0, probe);
    endtask

    logic [PW-1:0] cur;

    initial begin
        // Single entry from a constant probe, window of eight cycles
        probe = 16'h0005;
        doReset();
        applyStimulus(1, 0, 0, 16'h0005);
        for (int i = 1; i <= 11; i++) applyStimulus(0, 0, 0, 16'h0005);
        checkOutput("t1_count", 64'(count), 64'(1));
        checkOutput("t1_entry", 64'(rd_data), 64'({4'h0, 16'h0005}));
        checkOutput("t1_done", 64'(done), 64'(1));
        checkOutput("t1_ovf", 64'(overflow), 64'(0));

        // Channel 0 changes at ts=3 and ts=5
        applyStimulus(1, 0, 0, 16'h3311);
        for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 16'h3311);
        applyStimulus(0, 0, 0, 16'h3322);
        applyStimulus(0, 0, 0, 16'h3322);
        for (int i = 6; i <= 9; i++) applyStimulus(0, 0, 0, 16'h3333);
        applyStimulus(0, 0, 1, 16'h3333);
        checkOutput("t2_e0", 64'(rd_data), 64'({4'd0, 16'h3311}));
        applyStimulus(0, 0, 1, 16'h3333);
        checkOutput("t2_e1", 64'(rd_data), 64'({4'd3, 16'h3322}));
        applyStimulus(0, 0, 1, 16'h3333);
        checkOutput("t2_e2", 64'(rd_data), 64'({4'd5, 16'h3333}));
        applyStimulus(0, 0, 0, 16'h3333);
        checkOutput("t2_empty", 64'(count), 64'(0));

        // Probe toggles every cycle with no reads
        applyStimulus(1, 0, 0, 16'h00FF);
        for (int i = 1; i <= 10; i++)
            applyStimulus(0, 0, 0, (i >= 2 && i % 2 == 0) ? 16'hFF00 : 16'h00FF);
        checkOutput("t3_count", 64'(count), 64'(4));
        checkOutput("t3_done", 64'(done), 64'(1));
`ifdef TRACE_STOP_ON_FULL_EN
        checkOutput("t3_ovf", 64'(overflow), 64'(0));
`else
        checkOutput("t3_ovf", 64'(overflow), 64'(1));
`endif

        // Fill, then stream with rd_en every cycle while full
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        for (int i = 2; i <= 9; i++) begin
            applyStimulus(0, 0, (i >= 5), PW'(i - 1));
`ifndef TRACE_STOP_ON_FULL_EN
            if (i >= 5) checkOutput("t4_count", 64'(count), 64'(4));
`endif
        end
        checkOutput("t4_ovf", 64'(overflow), 64'(0));

        // arm together with stop at ts=2, then stop alone at ts=2
        applyStimulus(1, 0, 0, 16'h0101);
        applyStimulus(0, 0, 0, 16'h0101);
        applyStimulus(0, 0, 0, 16'h0102);
        applyStimulus(1, 1, 0, 16'h0103);
        applyStimulus(0, 0, 0, 16'h0A0A);
        checkOutput("t5_flush", 64'(count), 64'(0));
        applyStimulus(0, 0, 0, 16'h0A0A);
        checkOutput("t5_armed", 64'(rd_data), 64'({4'd0, 16'h0A0A}));
        applyStimulus(0, 1, 0, 16'h0B0B);
        applyStimulus(0, 0, 0, 16'h0C0C);
        checkOutput("t5_done", 64'(done), 64'(1));
        applyStimulus(0, 0, 0, 16'h0D0D);
        checkOutput("t5_nopush", 64'(count), 64'(2));

        // rst in the middle of a capture, then a read while empty
        applyStimulus(1, 0, 0, 16'h1111);
        for (int i = 1; i <= 5; i++) applyStimulus(0, 0, 0, PW'(16'h1111 + i));
        doReset();
        applyStimulus(0, 0, 1, 16'h2222);
        applyStimulus(0, 0, 0, 16'h2222);
        checkOutput("t6_count", 64'(count), 64'(0));
        checkOutput("t6_valid", 64'(rd_valid), 64'(0));

        // Random traffic
        cur = probe;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                if ($urandom_range(0, 99) < 45) cur = PW'($urandom);
                applyStimulus(
                    $urandom_range(0, 99) < ((phase == P_IDLE || phase == P_DONE) ? 20 : 3),
                    $urandom_range(0, 99) < 5,
                    $urandom_range(0, 1) == 1,
                    cur);
            end
        end
        @(negedge clk);
        checkState("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
